exec_sequencer: RTL and testbench

Micro-sequencer driving the control inputs of the byte/word execution datapath: ALU operand buffers, internal-bus source, output mux, flag register and write-back strobes. It accepts one decoded micro-operation per start handshake. It steps the datapath through operand fetch, execute, write-back and flag update, one state per clock, and reports completion to the instruction decoder. It sits between the decoder and the execution datapath and is the only driver of that datapath's control pins.

---
 rtl/exec_pkg.sv | 33 +++
 rtl/exec_ctl_decode.sv | 37 +++
 rtl/exec_sequencer.sv | 79 +++++++
 tb/tb_exec_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared state, opcode-class and datapath control encodings for the execution sequencer
package exec_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH_A, S_FETCH_B, S_EXEC, S_WRITE, S_FLAGS, S_DONE} state_t;
  localparam logic [1:0] OP_RR = 2'd0, OP_RI = 2'd1, OP_ADDR = 2'd2, OP_FLAG = 2'd3;
  localparam logic [1:0] BUF_NONE = 2'd0, BUF_A = 2'd1, BUF_B = 2'd2;
  localparam logic [1:0] MISC_BUS = 2'd0, MISC_ARITH = 2'd1, MISC_LOGIC = 2'd2, MISC_FLAGS = 2'd3;
  localparam logic [1:0] BRS_ADDR_LO = 2'd0, BRS_ADDR_HI = 2'd1, BRS_DATA_IN = 2'd2, BRS_DATA_OUT = 2'd3;
  localparam logic BRS_DRIVE = 1'b1;
  localparam logic [1:0] CY_FLAG = 2'd0, CY_A7 = 2'd1, CY_ONE = 2'd2, CY_ZERO = 2'd3;
  typedef struct packed {
    logic [1:0] op_class;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] dst_sel;
    logic [3:0] alu_op;
    logic       alu_mode;
    logic [1:0] cy_mode;
    logic [1:0] word_sel;
  } uop_t;
  typedef struct packed {
    logic [3:0] alu_opcode;
    logic       alu_m;
    logic [1:0] cy_sel;
    logic [1:0] buff_sel;
    logic [2:0] byte_reg_sel;
    logic [1:0] misc;
    logic [1:0] word_reg_sel;
    logic [2:0] wb_sel;
    logic       wb_en;
    logic       flag_latch_en;
    logic       stfr;
  } ctl_t;
endpackage

// File: rtl/exec_ctl_decode.sv
// exec_ctl_decode: combinational map from sequencer state and micro-op fields to datapath controls
module exec_ctl_decode
  import exec_pkg::*;
(
  input  state_t st,
  input  uop_t   uop,
  output ctl_t   ctl
);
  always_comb begin
    ctl = '0;
    case (st)
      S_FETCH_A: begin
        ctl.byte_reg_sel = {BRS_DRIVE, uop.src_a};
        ctl.buff_sel = BUF_A;
      end
      S_FETCH_B: begin
        ctl.byte_reg_sel = {BRS_DRIVE, (uop.op_class == OP_RI) ? BRS_DATA_IN : uop.src_b};
        ctl.buff_sel = BUF_B;
      end
      S_EXEC, S_WRITE: begin
        ctl.alu_opcode = uop.alu_op;
        ctl.alu_m = uop.alu_mode;
        ctl.cy_sel = uop.cy_mode;
        ctl.misc = uop.alu_mode ? MISC_LOGIC : MISC_ARITH;
        ctl.word_reg_sel = (uop.op_class == OP_ADDR) ? uop.word_sel : 2'd0;
        ctl.wb_en = (st == S_WRITE);
        ctl.wb_sel = (st == S_WRITE) ? uop.dst_sel : 3'd0;
      end
      S_FLAGS: begin
        ctl.misc = MISC_FLAGS;
        ctl.flag_latch_en = 1'b1;
        ctl.stfr = (uop.op_class == OP_FLAG);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: steps the execution datapath through fetch/exec/write-back/flag phases per micro-op
module exec_sequencer
  import exec_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic       start,
  input  logic [1:0] opClass,
  input  logic [2:0] srcA,
  input  logic [2:0] srcB,
  input  logic [2:0] dstSel,
  input  logic [3:0] aluOp,
  input  logic       aluMode,
  input  logic [1:0] cyMode,
  input  logic       setFlags,
  input  logic [1:0] wordSel,
  output logic       busy,
  output logic       done,
  output logic [3:0] ALUOpecode,
  output logic       ALU_M,
  output logic [1:0] cySelector,
  output logic [1:0] buffSel,
  output logic [2:0] byteRegSelector,
  output logic [1:0] misc,
  output logic [1:0] wordRegSelector,
  output logic [2:0] writeBackSel,
  output logic       writeBackEnable,
  output logic       flagLatchEn,
  output logic       stfr
);
  state_t state, next_state;
  uop_t uop_q, uop_d;
  ctl_t ctl_d, ctl_q;
  logic set_flags_q;
  logic accept;
  assign accept = (state == S_IDLE) && start;
  assign uop_d = accept ? {opClass, 2'(srcA), 2'(srcB), dstSel, aluOp, aluMode, cyMode, wordSel} : uop_q;
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    next_state = start ? S_FETCH_A : S_IDLE;
      S_FETCH_A: next_state = (uop_q.op_class == OP_FLAG) ? S_FLAGS : S_FETCH_B;
      S_FETCH_B: next_state = S_EXEC;
      S_EXEC:    next_state = S_WRITE;
      S_WRITE:   next_state = (uop_q.op_class != OP_ADDR && set_flags_q) ? S_FLAGS : S_DONE;
      S_FLAGS:   next_state = S_DONE;
      default:   next_state = S_IDLE;
    endcase
  end
  exec_ctl_decode u_decode (.st(next_state), .uop(uop_d), .ctl(ctl_d));
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
      uop_q <= '0;
      set_flags_q <= 1'b0;
      ctl_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= next_state;
      uop_q <= uop_d;
      set_flags_q <= accept ? setFlags : set_flags_q;
      ctl_q <= ctl_d;
      busy <= (next_state != S_IDLE);
      done <= (next_state == S_DONE);
    end
  end
  assign ALUOpecode = ctl_q.alu_opcode;
  assign ALU_M = ctl_q.alu_m;
  assign cySelector = ctl_q.cy_sel;
  assign buffSel = ctl_q.buff_sel;
  assign byteRegSelector = ctl_q.byte_reg_sel;
  assign misc = ctl_q.misc;
  assign wordRegSelector = ctl_q.word_reg_sel;
  assign writeBackSel = ctl_q.wb_sel;
  assign writeBackEnable = ctl_q.wb_en;
  assign flagLatchEn = ctl_q.flag_latch_en;
  assign stfr = ctl_q.stfr;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed self-checking bench for exec_sequencer
module tb_exec_sequencer;
  logic clk = 1'b0, nReset = 1'b1, start = 1'b0;
  logic [1:0] opClass = '0, cyMode = '0, wordSel = '0;
  logic [2:0] srcA = '0, srcB = '0, dstSel = '0;
  logic [3:0] aluOp = '0;
  logic aluMode = 1'b0, setFlags = 1'b0;
  logic busy, done, ALU_M, writeBackEnable, flagLatchEn, stfr;
  logic [3:0] ALUOpecode;
  logic [1:0] cySelector, buffSel, misc, wordRegSelector;
  logic [2:0] byteRegSelector, writeBackSel;
  logic [23:0] all_out;
  int checks = 0, passed = 0;
  logic flag_seen = 1'b0, bufb_seen = 1'b0;
  exec_sequencer dut (
    .clk(clk), .nReset(nReset), .start(start), .opClass(opClass), .srcA(srcA), .srcB(srcB),
    .dstSel(dstSel), .aluOp(aluOp), .aluMode(aluMode), .cyMode(cyMode), .setFlags(setFlags),
    .wordSel(wordSel), .busy(busy), .done(done), .ALUOpecode(ALUOpecode), .ALU_M(ALU_M),
    .cySelector(cySelector), .buffSel(buffSel), .byteRegSelector(byteRegSelector), .misc(misc),
    .wordRegSelector(wordRegSelector), .writeBackSel(writeBackSel),
    .writeBackEnable(writeBackEnable), .flagLatchEn(flagLatchEn), .stfr(stfr)
  );
  assign all_out = {ALUOpecode, ALU_M, cySelector, buffSel, byteRegSelector, misc, wordRegSelector,
                    writeBackSel, writeBackEnable, flagLatchEn, stfr, busy, done};
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
    flag_seen = flag_seen | flagLatchEn;
    bufb_seen = bufb_seen | (buffSel == 2'd2);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic go(input logic [1:0] oc, input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] ds,
                    input logic [3:0] op, input logic am, input logic [1:0] cm, input logic sf, input logic [1:0] ws);
    opClass = oc; srcA = sa; srcB = sb; dstSel = ds; aluOp = op;
    aluMode = am; cyMode = cm; setFlags = sf; wordSel = ws;
    flag_seen = 1'b0; bufb_seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    #1 nReset = 1'b0;
    #10 chk("reset_outputs", 32'(all_out), 32'h0);
    @(negedge clk) nReset = 1'b1;
    tick();
    chk("idle_outputs", 32'(all_out), 32'h0);
    go(2'd0, 3'd1, 3'd3, 3'd5, 4'h9, 1'b0, 2'd1, 1'b1, 2'd0);
    chk("rr_c1_fetch_a", 32'({busy, done, buffSel, byteRegSelector}), 32'({1'b1, 1'b0, 2'd1, 3'b101}));
    tick();
    chk("rr_c2_fetch_b", 32'({buffSel, byteRegSelector}), 32'({2'd2, 3'b111}));
    tick();
    chk("rr_c3_exec", 32'({buffSel, ALUOpecode, ALU_M, cySelector, misc, writeBackEnable}),
        32'({2'd0, 4'h9, 1'b0, 2'd1, 2'd1, 1'b0}));
    tick();
    chk("rr_c4_write", 32'({buffSel, writeBackEnable, writeBackSel, ALUOpecode, misc, flagLatchEn}),
        32'({2'd0, 1'b1, 3'd5, 4'h9, 2'd1, 1'b0}));
    tick();
    chk("rr_c5_flags", 32'({flagLatchEn, stfr, writeBackEnable, buffSel, done}), 32'({1'b1, 1'b0, 1'b0, 2'd0, 1'b0}));
    tick();
    chk("rr_c6_done", 32'({done, busy, flagLatchEn}), 32'({1'b1, 1'b1, 1'b0}));
    tick();
    chk("rr_c7_idle", 32'(all_out), 32'h0);
    go(2'd1, 3'd0, 3'd5, 3'd2, 4'h3, 1'b1, 2'd3, 1'b0, 2'd0);
    chk("imm_c1_fetch_a", 32'({buffSel, byteRegSelector}), 32'({2'd1, 3'b100}));
    tick();
    chk("imm_c2_fetch_b", 32'({buffSel, byteRegSelector}), 32'({2'd2, 3'b110}));
    tick();
    chk("imm_c3_exec", 32'({ALU_M, misc, cySelector, ALUOpecode}), 32'({1'b1, 2'd2, 2'd3, 4'h3}));
    tick();
    chk("imm_c4_write", 32'({writeBackEnable, writeBackSel, done}), 32'({1'b1, 3'd2, 1'b0}));
    tick();
    chk("imm_c5_done", 32'({done, busy, writeBackEnable}), 32'({1'b1, 1'b1, 1'b0}));
    chk("imm_no_flags", 32'(flag_seen), 32'h0);
    tick();
    chk("imm_c6_idle", 32'({busy, done}), 32'h0);
    go(2'd3, 3'd2, 3'd1, 3'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("fl_c1_fetch_a", 32'({buffSel, byteRegSelector, stfr}), 32'({2'd1, 3'b110, 1'b0}));
    tick();
    chk("fl_c2_flags", 32'({stfr, flagLatchEn, buffSel, done}), 32'({1'b1, 1'b1, 2'd0, 1'b0}));
    tick();
    chk("fl_c3_done", 32'({done, stfr, flagLatchEn}), 32'({1'b1, 1'b0, 1'b0}));
    chk("fl_no_buf_b", 32'(bufb_seen), 32'h0);
    tick();
    chk("fl_c4_idle", 32'({busy, done}), 32'h0);
    go(2'd2, 3'd0, 3'd1, 3'd7, 4'h2, 1'b0, 2'd0, 1'b1, 2'd2);
    tick();
    tick();
    chk("ad_c3_exec", 32'({wordRegSelector, misc, writeBackEnable}), 32'({2'd2, 2'd1, 1'b0}));
    tick();
    chk("ad_c4_write", 32'({wordRegSelector, writeBackEnable, writeBackSel}), 32'({2'd2, 1'b1, 3'd7}));
    tick();
    chk("ad_c5_done", 32'({done, wordRegSelector, writeBackEnable}), 32'({1'b1, 2'd0, 1'b0}));
    chk("ad_no_flags", 32'(flag_seen), 32'h0);
    tick();
    chk("ad_c6_idle", 32'({busy, done}), 32'h0);
    opClass = 2'd3; srcA = 3'd1; setFlags = 1'b0; start = 1'b1;
    tick();
    chk("hs_c1_fetch_a", 32'({busy, buffSel}), 32'({1'b1, 2'd1}));
    opClass = 2'd0; setFlags = 1'b1;
    tick();
    chk("hs_c2_captured", 32'({stfr, flagLatchEn, buffSel}), 32'({1'b1, 1'b1, 2'd0}));
    tick();
    chk("hs_c3_done", 32'({done, busy}), 32'({1'b1, 1'b1}));
    opClass = 2'd3;
    tick();
    chk("hs_c4_idle_gap", 32'({busy, done, buffSel}), 32'h0);
    tick();
    chk("hs_c5_next_fetch", 32'({busy, buffSel}), 32'({1'b1, 2'd1}));
    tick();
    chk("hs_c6_flags", 32'({stfr, flagLatchEn}), 32'({1'b1, 1'b1}));
    tick();
    chk("hs_c7_done", 32'(done), 32'h1);
    start = 1'b0;
    tick();
    tick();
    chk("hs_not_queued", 32'({busy, done}), 32'h0);
    go(2'd0, 3'd2, 3'd3, 3'd4, 4'hF, 1'b0, 2'd2, 1'b1, 2'd0);
    tick();
    tick();
    chk("rst_pre_exec", 32'(ALUOpecode), 32'hF);
    #2 nReset = 1'b0;
    #1 chk("rst_async_exec", 32'(all_out), 32'h0);
    @(negedge clk) nReset = 1'b1;
    tick();
    chk("rst_idle_after", 32'({busy, buffSel}), 32'h0);
    go(2'd1, 3'd1, 3'd0, 3'd6, 4'h1, 1'b0, 2'd0, 1'b1, 2'd0);
    tick();
    tick();
    tick();
    chk("rst_pre_write", 32'(writeBackEnable), 32'h1);
    #2 nReset = 1'b0;
    #1 chk("rst_wb_abandon", 32'({writeBackEnable, writeBackSel, busy}), 32'h0);
    @(negedge clk) nReset = 1'b1;
    tick();
    chk("rst_idle_after2", 32'(all_out), 32'h0);
    go(2'd3, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("rst_first_start", 32'({busy, buffSel, byteRegSelector}), 32'({1'b1, 2'd1, 3'b100}));
    tick();
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
